// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: picks a victim way, optionally writes back a dirty victim,
// issues a tagged LOAD, waits for the matching tag and fills the cache line. Option macro: VICTIM_WRITEBACK_EN.
module cache_fill_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MTAG_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              repl_req,
  input  logic [WAY_W-1:0]  repl_way,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [DATA_W-1:0] victim_data,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [MTAG_W-1:0] mem2proc_response,
  input  logic [MTAG_W-1:0] mem2proc_tag,
  input  logic [DATA_W-1:0] mem2proc_data,
  output logic              fill_valid,
  output logic [WAY_W-1:0]  fill_way,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              use_valid,
  output logic [WAY_W-1:0]  use_way
);

  typedef enum logic [2:0] {IDLE, VICTIM, WB, REQ, WAIT, FILL} state_t;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   missAddr_q, missAddr_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [MTAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]   lineData_q, lineData_d;
`ifdef VICTIM_WRITEBACK_EN
  logic [ADDR_W-1:0]   victimAddr_q, victimAddr_d;
  logic [DATA_W-1:0]   victimData_q, victimData_d;
`else
  logic                unusedVictim;
  assign unusedVictim = ^{victim_dirty, victim_addr, victim_data};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      missAddr_q <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      lineData_q <= '0;
`ifdef VICTIM_WRITEBACK_EN
      victimAddr_q <= '0;
      victimData_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      missAddr_q <= missAddr_d;
      way_q      <= way_d;
      tag_q      <= tag_d;
      lineData_q <= lineData_d;
`ifdef VICTIM_WRITEBACK_EN
      victimAddr_q <= victimAddr_d;
      victimData_q <= victimData_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    missAddr_d       = missAddr_q;
    way_d            = way_q;
    tag_d            = tag_q;
    lineData_d       = lineData_q;
`ifdef VICTIM_WRITEBACK_EN
    victimAddr_d     = victimAddr_q;
    victimData_d     = victimData_q;
`endif
    miss_ready       = 1'b0;
    repl_req         = 1'b0;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    fill_valid       = 1'b0;
    fill_way         = '0;
    fill_addr        = '0;
    fill_data        = '0;
    use_valid        = 1'b0;
    use_way          = '0;

    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          missAddr_d = miss_addr;
          state_d    = VICTIM;
        end
      end
      VICTIM: begin
        repl_req = 1'b1;
        way_d    = repl_way;
        state_d  = REQ;
`ifdef VICTIM_WRITEBACK_EN
        victimAddr_d = victim_addr;
        victimData_d = victim_data;
        if (victim_dirty) state_d = WB;
`endif
      end
      WB: begin
`ifdef VICTIM_WRITEBACK_EN
        proc2mem_command = CMD_STORE;
        proc2mem_addr    = victimAddr_q;
        proc2mem_data    = victimData_q;
        if (mem2proc_response != '0) state_d = REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: begin
        proc2mem_command = CMD_LOAD;
        proc2mem_addr    = missAddr_q;
        if (mem2proc_response != '0) begin
          tag_d   = mem2proc_response;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Only a registered, nonzero tag can match, so a same-cycle return during REQ is never taken.
        if ((tag_q != '0) && (mem2proc_tag == tag_q)) begin
          lineData_d = mem2proc_data;
          state_d    = FILL;
        end
      end
      FILL: begin
        fill_valid = 1'b1;
        fill_way   = way_q;
        fill_addr  = missAddr_q;
        fill_data  = lineData_q;
        use_valid  = 1'b1;
        use_way    = way_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl; expectations are hand-computed per cycle.
// Inputs change just after the falling edge and outputs are checked 1 time unit later.
module tb_cache_fill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        repl_req;
  logic [1:0]  repl_way;
  logic        victim_dirty;
  logic [31:0] victim_addr;
  logic [63:0] victim_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        fill_valid;
  logic [1:0]  fill_way;
  logic [31:0] fill_addr;
  logic [63:0] fill_data;
  logic        use_valid;
  logic [1:0]  use_way;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  cache_fill_ctrl dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .repl_req(repl_req), .repl_way(repl_way),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .fill_valid(fill_valid), .fill_way(fill_way), .fill_addr(fill_addr), .fill_data(fill_data),
    .use_valid(use_valid), .use_way(use_way)
  );

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, observed, expected, $time);
    end
  endtask

  // One cycle: drive the per-cycle inputs after the falling edge, then settle before checking.
  task automatic applyStimulus(input logic mv, input logic [31:0] ma, input logic [3:0] resp,
                               input logic [3:0] tag, input logic [63:0] mdata);
    @(negedge clock);
    miss_valid        = mv;
    miss_addr         = ma;
    mem2proc_response = resp;
    mem2proc_tag      = tag;
    mem2proc_data     = mdata;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; repl_way = '0;
    victim_dirty = 1'b0; victim_addr = '0; victim_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;

    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_miss_ready", miss_ready, 1);
    checkOutput("rst_repl_req", repl_req, 0);
    checkOutput("rst_cmd", proc2mem_command, 0);
    checkOutput("rst_fill_valid", fill_valid, 0);
    checkOutput("rst_use_valid", use_valid, 0);

    // Clean miss, tag returned two cycles after the load is accepted
    repl_way = 2'd2;
    applyStimulus(1, 32'h100, 0, 0, 0);
    checkOutput("t1_idle_ready", miss_ready, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_victim_req", repl_req, 1);
    checkOutput("t1_victim_ready", miss_ready, 0);
    checkOutput("t1_victim_cmd", proc2mem_command, 0);
    applyStimulus(0, 0, 3, 0, 0);
    checkOutput("t1_req_cmd", proc2mem_command, 1);
    checkOutput("t1_req_addr", proc2mem_addr, 64'h100);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_wait_cmd", proc2mem_command, 0);
    checkOutput("t1_wait_fill", fill_valid, 0);
    applyStimulus(0, 0, 0, 3, 64'hDEAD);
    checkOutput("t1_wait2_fill", fill_valid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_fill_valid", fill_valid, 1);
    checkOutput("t1_fill_way", fill_way, 2);
    checkOutput("t1_fill_addr", fill_addr, 64'h100);
    checkOutput("t1_fill_data", fill_data, 64'hDEAD);
    checkOutput("t1_use_valid", use_valid, 1);
    checkOutput("t1_use_way", use_way, 2);
    checkOutput("t1_fill_ready", miss_ready, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_after_fill", fill_valid, 0);
    checkOutput("t1_after_ready", miss_ready, 1);
    checkOutput("t1_after_data", fill_data, 0);

    // Dirty victim: written back first only when the write-back option is built in
    repl_way = 2'd1; victim_dirty = 1'b1; victim_addr = 32'h200; victim_data = 64'hBEEF;
    applyStimulus(1, 32'h400, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_victim_req", repl_req, 1);
    victim_dirty = 1'b0; victim_addr = '0; victim_data = '0;
`ifdef VICTIM_WRITEBACK_EN
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t2_wb_cmd", proc2mem_command, 2);
    checkOutput("t2_wb_addr", proc2mem_addr, 64'h200);
    checkOutput("t2_wb_data", proc2mem_data, 64'hBEEF);
`endif
    applyStimulus(0, 0, 6, 0, 0);
    checkOutput("t2_req_cmd", proc2mem_command, 1);
    checkOutput("t2_req_addr", proc2mem_addr, 64'h400);
    checkOutput("t2_req_data", proc2mem_data, 0);
    applyStimulus(0, 0, 0, 6, 64'hCAFE);
    checkOutput("t2_wait_cmd", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_fill_valid", fill_valid, 1);
    checkOutput("t2_fill_way", fill_way, 1);
    checkOutput("t2_fill_addr", fill_addr, 64'h400);
    checkOutput("t2_fill_data", fill_data, 64'hCAFE);
    applyStimulus(0, 0, 0, 0, 0);

    // Load refused three times, accepted with tag 5 while tag 5 also appears that same cycle
    repl_way = 2'd3;
    applyStimulus(1, 32'h300, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t3_retry_cmd", proc2mem_command, 1);
      checkOutput("t3_retry_addr", proc2mem_addr, 64'h300);
    end
    applyStimulus(0, 0, 5, 5, 64'h5A5A);
    checkOutput("t3_accept_cmd", proc2mem_command, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_sametag_fill", fill_valid, 0);
    checkOutput("t3_wait_cmd", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 4, 64'h4444);
    checkOutput("t3_tag4_fill", fill_valid, 0);
    applyStimulus(0, 0, 0, 5, 64'h5555);
    checkOutput("t3_tag5_fill", fill_valid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_fill_valid", fill_valid, 1);
    checkOutput("t3_fill_way", fill_way, 3);
    checkOutput("t3_fill_data", fill_data, 64'h5555);
    applyStimulus(0, 0, 0, 0, 0);

    // Miss held high throughout: no second victim request until after the fill
    repl_way = 2'd0;
    applyStimulus(1, 32'h500, 0, 0, 0);
    checkOutput("t4_idle_ready", miss_ready, 1);
    applyStimulus(1, 32'h600, 0, 0, 0);
    checkOutput("t4_victim_ready", miss_ready, 0);
    applyStimulus(1, 32'h600, 2, 0, 0);
    checkOutput("t4_req_ready", miss_ready, 0);
    checkOutput("t4_req_addr", proc2mem_addr, 64'h500);
    applyStimulus(1, 32'h600, 0, 0, 0);
    checkOutput("t4_wait_ready", miss_ready, 0);
    checkOutput("t4_wait_repl", repl_req, 0);
    applyStimulus(1, 32'h600, 0, 2, 64'h77);
    checkOutput("t4_wait2_repl", repl_req, 0);
    applyStimulus(1, 32'h600, 0, 0, 0);
    checkOutput("t4_fill_valid", fill_valid, 1);
    checkOutput("t4_fill_addr", fill_addr, 64'h500);
    checkOutput("t4_fill_ready", miss_ready, 0);
    applyStimulus(1, 32'h600, 0, 0, 0);
    checkOutput("t4_idle2_ready", miss_ready, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_victim2_req", repl_req, 1);

    // Reset while waiting abandons the tag; its later return must not fill
    applyStimulus(0, 0, 7, 0, 0);
    checkOutput("t5_req_addr", proc2mem_addr, 64'h600);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_wait_cmd", proc2mem_command, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_rst_fill", fill_valid, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 7, 64'hBAD);
    checkOutput("t5_post_ready", miss_ready, 1);
    checkOutput("t5_post_fill", fill_valid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_late_fill", fill_valid, 0);
    checkOutput("t5_late_ready", miss_ready, 1);
    checkOutput("t5_late_cmd", proc2mem_command, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter NUM_WAYS, default 4, number of cache ways; way index width WAY_W = $clog2(NUM_WAYS).
REQ-002 Parameter ADDR_W, default 32, memory byte-address width.
REQ-003 Parameter DATA_W, default 64, memory/cache line width.
REQ-004 Parameter MTAG_W, default 4, memory transaction tag width; tag 0 SHALL mean "no transaction".
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 miss_valid  input  1  cache reports a miss on miss_addr.
REQ-008 miss_addr  input  ADDR_W  line-aligned miss address.
REQ-009 miss_ready  output  1  controller idle, miss accepted this cycle.
REQ-010 repl_req  output  1  victim request to replacement policy (drives its write-request strobe).
REQ-011 repl_way  input  WAY_W  victim way from replacement policy, valid combinationally while repl_req high.
REQ-012 victim_dirty, victim_addr, victim_data  input  1/ADDR_W/DATA_W  state of the line in repl_way.
REQ-013 proc2mem_command  output  2  0=NONE, 1=LOAD, 2=STORE.
REQ-014 proc2mem_addr, proc2mem_data  output  ADDR_W/DATA_W  memory request address/store data.
REQ-015 mem2proc_response  input  MTAG_W  nonzero = request accepted, value = assigned tag.
REQ-016 mem2proc_tag, mem2proc_data  input  MTAG_W/DATA_W  returning load tag and data.
REQ-017 fill_valid, fill_way, fill_addr, fill_data  output  1/WAY_W/ADDR_W/DATA_W  one-cycle cache line write.
REQ-018 use_valid, use_way  output  1/WAY_W  use update to replacement policy (its proc_valid/proc_way).

Function
REQ-019 FSM states SHALL be IDLE, VICTIM, WB, REQ, WAIT, FILL.
REQ-020 IDLE: miss_ready=1; miss_valid=1 -> capture miss_addr, go VICTIM; otherwise stay.
REQ-021 VICTIM (exactly 1 cycle): repl_req=1; capture repl_way and victim_*; go WB if captured dirty and VICTIM_WRITEBACK_EN defined, else REQ.
REQ-022 WB: command=STORE, addr/data = captured victim; response nonzero -> REQ; response 0 -> stay and retry next cycle; store tag not tracked.
REQ-023 REQ: command=LOAD, addr=captured miss_addr; response nonzero -> capture tag, go WAIT; 0 -> retry.
REQ-024 WAIT: command=NONE; mem2proc_tag equal to captured tag and nonzero -> capture mem2proc_data, go FILL; otherwise stay, no timeout.
REQ-025 Tag matching SHALL occur only in WAIT; a tag returned in the same cycle the load is accepted SHALL NOT match.
REQ-026 FILL (exactly 1 cycle): fill_valid=1, use_valid=1, fill_way=use_way=captured way, fill_addr=captured miss_addr, fill_data=captured load data; go IDLE.
REQ-027 miss_ready SHALL be 0 in every non-IDLE state; misses presented then are ignored, not queued.
REQ-028 Outputs not asserted by the current state SHALL be 0 (command NONE, strobes low, buses 0).
REQ-029 Minimum miss-to-fill latency: accept at cycle 0, VICTIM 1, REQ 2, WAIT 3, FILL at cycle 3+memory latency; a new miss may be accepted the cycle after FILL.

Reset
REQ-030 reset SHALL force IDLE and clear all captured registers; takes priority over any transition.
REQ-031 During and after reset, miss_ready=1 (once out of reset) and all other outputs 0; an in-flight memory tag is abandoned and later responses with it SHALL be ignored.

Configuration
REQ-032 Macro VICTIM_WRITEBACK_EN: defined -> dirty victims stored via WB before LOAD; undefined -> WB state unreachable, victim_dirty/addr/data ignored, STORE never issued.

Verification
REQ-033 Clean miss addr 0x100, repl_way=2, response 3 on first REQ cycle, tag 3 two cycles later, data 0xDEAD -> LOAD@0x100 once, fill_valid one cycle with way 2, data 0xDEAD, use_valid way 2.
REQ-034 With VICTIM_WRITEBACK_EN, dirty victim addr 0x200 data 0xBEEF -> STORE@0x200/0xBEEF precedes LOAD@miss addr; without macro no STORE.
REQ-035 Response 0 for 3 cycles in REQ then 5 -> LOAD held 4 cycles, WAIT entered; tag 4 ignored, tag 5 fills.
REQ-036 miss_valid asserted continuously during WAIT -> miss_ready=0, no second VICTIM until after FILL.
REQ-037 reset asserted in WAIT, then matching tag returned after reset -> no fill_valid, state IDLE, miss_ready=1.
